hazard_forward_ctrl: RTL and testbench

//  Sequencing/control for the EX-stage operand forwarding muxes of the 5-stage MIPS pipeline.

---
 rtl/hazard_forward_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
// EX-stage operand forwarding and hazard control for a 5-stage MIPS pipeline.
// A shadow pipeline of destination info (EX, MEM, WB) sits beside the ID
// decoder. Forward selects are registered as an instruction enters EX. Load-use
// and HI/LO (mult/div) hazards hold PC and IF_ID and insert an ID_EX bubble.

module hazard_forward_ctrl #(
  parameter int REG_W      = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_is_muldiv,
  input  logic             id_reads_hilo,
  input  logic             flush_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_bubble,
  output logic             muldiv_start,
  output logic             hilo_busy
);

  // Operand mux encoding seen by the EX stage datapath.
  typedef enum logic [1:0] {
    FWD_ID_EX  = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwdSel_e;

  // Destination info carried down every shadow stage.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } dstInfo_t;

  // The EX stage also remembers which sources its instruction reads.
  typedef struct packed {
    dstInfo_t         dst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             usesRs;
    logic             usesRt;
  } exInfo_t;

  exInfo_t          exStage;
  dstInfo_t         memStage;
  dstInfo_t         wbStage;
  logic [CNT_W-1:0] busyCnt;

  logic             loadUse;
  logic             hiloHzd;
  logic             stall;
  logic             bubble;
  logic             issueMuldiv;
  exInfo_t          idEntry;
  fwdSel_e          fwdANext;
  fwdSel_e          fwdBNext;

  // Choose the newest in-flight producer of src. 'newer' is the instruction
  // that will sit in EX_MEM next cycle, 'older' the one that will sit in MEM_WB.
  // Register 0 is hardwired, so it is never forwarded.
  function automatic fwdSel_e pickSource(input logic             uses,
                                         input logic [REG_W-1:0] src,
                                         input dstInfo_t         newer,
                                         input dstInfo_t         older);
    if (!uses || src == '0)                  return FWD_ID_EX;
    if (newer.regwrite && newer.rd == src)   return FWD_EX_MEM;
    if (older.regwrite && older.rd == src)   return FWD_MEM_WB;
    return FWD_ID_EX;
  endfunction

  // Hazard detection against the instruction currently in EX and the mult/div counter.
  assign loadUse = exStage.dst.memread & exStage.dst.regwrite & (exStage.dst.rd != '0) &
                   ((id_uses_rs & (id_rs == exStage.dst.rd)) |
                    (id_uses_rt & (id_rt == exStage.dst.rd)));
  assign hiloHzd = (id_reads_hilo | id_is_muldiv) & (busyCnt != '0);

  // A squashed instruction never stalls: the fetch of the branch target must proceed.
  assign stall          = id_valid & ~flush_id & (loadUse | hiloHzd);
  assign bubble         = stall | flush_id | ~id_valid;
  assign issueMuldiv    = id_is_muldiv & ~bubble;

  assign pc_write_en    = ~stall;
  assign if_id_write_en = ~stall;
  assign id_ex_bubble   = bubble;
  assign hilo_busy      = (busyCnt != '0);

  // Build the EX-stage entry for the ID instruction and its forward selects.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    idEntry  = '0;
    fwdANext = FWD_ID_EX;
    fwdBNext = FWD_ID_EX;
    if (!bubble) begin
      idEntry.dst.valid    = 1'b1;
      idEntry.dst.rd       = id_rd;
      idEntry.dst.regwrite = id_regwrite;
      idEntry.dst.memread  = id_memread;
      idEntry.rs           = id_rs;
      idEntry.rt           = id_rt;
      idEntry.usesRs       = id_uses_rs;
      idEntry.usesRt       = id_uses_rt;
      fwdANext = pickSource(id_uses_rs, id_rs, exStage.dst, memStage);
      fwdBNext = pickSource(id_uses_rt, id_rt, exStage.dst, memStage);
    end
  end

  // Shadow pipeline advances every cycle; a bubble enters EX as all zeros.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exStage  <= '0;
      memStage <= '0;
      wbStage  <= '0;
    end else begin
      // NOTE: non-blocking assignments read the pre-edge values, so all three stages shift together regardless of statement order.
      exStage  <= idEntry;
      memStage <= exStage.dst;
      wbStage  <= memStage;
    end
  end

  // Forward selects are registered so they are stable for the whole EX cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fwd_a_sel <= FWD_ID_EX;
      fwd_b_sel <= FWD_ID_EX;
    end else begin
      fwd_a_sel <= fwdANext;
      fwd_b_sel <= fwdBNext;
    end
  end

  // HI/LO occupancy counter and the start pulse for the mult/div unit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busyCnt      <= '0;
      muldiv_start <= 1'b0;
    end else begin
      muldiv_start <= issueMuldiv;
      if (issueMuldiv) begin
        busyCnt <= CNT_W'(MULDIV_LAT);
      end else if (busyCnt != '0) begin
        busyCnt <= busyCnt - CNT_W'(1);
      end
    end
  end

  // Fields below do not feed the select/stall logic; they keep stage alignment
  // visible for the consistency properties and for waveform debug.
  logic unusedShadow;
  assign unusedShadow = ^{exStage.dst.valid, exStage.rs, exStage.rt, exStage.usesRs,
                          exStage.usesRt, memStage, wbStage};

  // A registered EX_MEM select must point at the producer now in MEM, which
  // can never be a load (that case stalls instead).
  assert property (@(posedge clk) disable iff (!reset)
    (fwd_a_sel == FWD_EX_MEM) |-> (exStage.usesRs && exStage.rs != '0 && memStage.regwrite &&
                                   !memStage.memread && memStage.rd == exStage.rs));
  assert property (@(posedge clk) disable iff (!reset)
    (fwd_b_sel == FWD_EX_MEM) |-> (exStage.usesRt && exStage.rt != '0 && memStage.regwrite &&
                                   !memStage.memread && memStage.rd == exStage.rt));

  // A registered MEM_WB select must point at the producer now in WB, with no newer match in MEM.
  assert property (@(posedge clk) disable iff (!reset)
    (fwd_a_sel == FWD_MEM_WB) |-> (exStage.usesRs && exStage.rs != '0 && wbStage.regwrite &&
                                   wbStage.rd == exStage.rs &&
                                   !(memStage.regwrite && memStage.rd == exStage.rs)));
  assert property (@(posedge clk) disable iff (!reset)
    (fwd_b_sel == FWD_MEM_WB) |-> (exStage.usesRt && exStage.rt != '0 && wbStage.regwrite &&
                                   wbStage.rd == exStage.rt &&
                                   !(memStage.regwrite && memStage.rd == exStage.rt)));

  // Encoding 11 is unused; the counter never exceeds its load value.
  assert property (@(posedge clk) disable iff (!reset)
    (fwd_a_sel != 2'b11) && (fwd_b_sel != 2'b11) && (busyCnt <= CNT_W'(MULDIV_LAT)));

  // The start pulse coincides with a freshly loaded counter.
  assert property (@(posedge clk) disable iff (!reset)
    muldiv_start |-> (busyCnt == CNT_W'(MULDIV_LAT)));

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl
// Directed table of instruction sequences with hand-derived per-cycle outputs,
// then randomized instruction streams checked against a history-based model.

module tb_hazard_forward_ctrl;

  localparam int REG_W  = 5;
  localparam int LAT    = 4;
  localparam int MAXC   = 2400;
  localparam int N_RAND = 1500;

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic             id_is_muldiv, id_reads_hilo, flush_id;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             pc_write_en, if_id_write_en, id_ex_bubble, muldiv_start, hilo_busy;

  hazard_forward_ctrl #(.REG_W(REG_W), .MULDIV_LAT(LAT), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo), .flush_id(flush_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_write_en(pc_write_en),
    .if_id_write_en(if_id_write_en), .id_ex_bubble(id_ex_bubble),
    .muldiv_start(muldiv_start), .hilo_busy(hilo_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    bit       valid;
    bit [4:0] rs, rt, rd;
    bit       usesRs, usesRt, regwrite, memread, muldiv, readsHilo;
  } inst_t;

  typedef struct packed {
    inst_t    inst;
    bit       flush, rstN;
    bit [1:0] selA, selB;
    bit       pcWe, bubble, mdStart, busy;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp, input int c);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic inst_t nop();
    return '0;
  endfunction
  function automatic inst_t alu(bit [4:0] rd, bit [4:0] rs, bit [4:0] rt);
    inst_t i = '0;
    i.valid = 1; i.rd = rd; i.rs = rs; i.rt = rt; i.usesRs = 1; i.usesRt = 1; i.regwrite = 1;
    return i;
  endfunction
  function automatic inst_t lw(bit [4:0] rd, bit [4:0] rs);
    inst_t i = '0;
    i.valid = 1; i.rd = rd; i.rs = rs; i.usesRs = 1; i.regwrite = 1; i.memread = 1;
    return i;
  endfunction
  function automatic inst_t mult(bit [4:0] rs, bit [4:0] rt);
    inst_t i = '0;
    i.valid = 1; i.rs = rs; i.rt = rt; i.usesRs = 1; i.usesRt = 1; i.muldiv = 1;
    return i;
  endfunction
  function automatic inst_t mflo(bit [4:0] rd);
    inst_t i = '0;
    i.valid = 1; i.rd = rd; i.regwrite = 1; i.readsHilo = 1;
    return i;
  endfunction

  function automatic inst_t randInst();
    int k = $urandom_range(0, 99);
    bit [4:0] a = 5'($urandom_range(0, 3));
    bit [4:0] b = 5'($urandom_range(0, 3));
    bit [4:0] d = 5'($urandom_range(0, 3));
    inst_t i;
    if (k < 10)      i = nop();
    else if (k < 40) i = alu(d, a, b);
    else if (k < 65) i = lw(d, a);
    else if (k < 75) i = mult(a, b);
    else if (k < 85) i = mflo(d);
    else begin
      i = alu(d, a, b);
      i.usesRt = 0;
    end
    return i;
  endfunction

  function automatic vec_t mk(inst_t i, bit fl, bit rn, bit [1:0] a, bit [1:0] b,
                              bit pc, bit bub, bit md, bit busy);
    vec_t v;
    v.inst = i; v.flush = fl; v.rstN = rn; v.selA = a; v.selB = b;
    v.pcWe = pc; v.bubble = bub; v.mdStart = md; v.busy = busy;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // exAt[c] is the instruction occupying EX during cycle c (zero for a bubble).
  // The producer heading for EX_MEM is exAt[c], the one heading for MEM_WB is
  // exAt[c-1]. HI/LO is busy for LAT cycles counted from the cycle the mult/div
  // is in EX. A reset wipes every history entry up to and including its cycle.
  inst_t    exAt [MAXC];
  bit [1:0] expA [MAXC];
  bit [1:0] expB [MAXC];
  int       resetUpTo = 0;
  int       lastMd    = -1000;
  int       cyc       = 0;
  bit       synced    = 0;

  function automatic inst_t occupant(int c);
    if (c < 0 || c <= resetUpTo) return '0;
    return exAt[c];
  endfunction

  function automatic bit readsReg(inst_t i, bit [4:0] r);
    return (i.usesRs && i.rs == r) || (i.usesRt && i.rt == r);
  endfunction

  function automatic bit [1:0] fwdModel(bit uses, bit [4:0] src, int t);
    inst_t p;
    if (!uses || src == 0) return 2'd0;
    for (int age = 0; age < 2; age++) begin
      p = occupant(t - age);
      if (p.regwrite && p.rd == src) return (age == 0) ? 2'd2 : 2'd1;
    end
    return 2'd0;
  endfunction

  // One clock cycle: drive ID inputs, check outputs at the falling edge, advance the model.
  task automatic runCycle(input inst_t in, input bit flush, input bit rstN,
                          input bit hasExp, input vec_t v, output bit stalled);
    inst_t ex;
    bit    loadUse, busy, stall, bubble;
    id_valid = in.valid;   id_rs = in.rs;               id_rt = in.rt;
    id_rd = in.rd;         id_uses_rs = in.usesRs;      id_uses_rt = in.usesRt;
    id_regwrite = in.regwrite; id_memread = in.memread; id_is_muldiv = in.muldiv;
    id_reads_hilo = in.readsHilo; flush_id = flush;    reset = rstN;
    @(negedge clk);
    ex      = occupant(cyc);
    loadUse = ex.memread && ex.regwrite && ex.rd != 0 && readsReg(in, ex.rd);
    busy    = (cyc - lastMd) < LAT;
    stall   = in.valid && !flush && (loadUse || ((in.readsHilo || in.muldiv) && busy));
    bubble  = stall || flush || !in.valid;
    if (synced) begin
      check("model pc_write_en",    pc_write_en,    !stall,              cyc);
      check("model if_id_write_en", if_id_write_en, !stall,              cyc);
      check("model id_ex_bubble",   id_ex_bubble,   bubble,              cyc);
      check("model hilo_busy",      hilo_busy,      busy,                cyc);
      check("model muldiv_start",   muldiv_start,   ex.valid && ex.muldiv, cyc);
      check("model fwd_a_sel",      fwd_a_sel,      expA[cyc],           cyc);
      check("model fwd_b_sel",      fwd_b_sel,      expB[cyc],           cyc);
    end
    if (hasExp) begin
      check("table fwd_a_sel",      fwd_a_sel,      v.selA,    cyc);
      check("table fwd_b_sel",      fwd_b_sel,      v.selB,    cyc);
      check("table pc_write_en",    pc_write_en,    v.pcWe,    cyc);
      check("table if_id_write_en", if_id_write_en, v.pcWe,    cyc);
      check("table id_ex_bubble",   id_ex_bubble,   v.bubble,  cyc);
      check("table muldiv_start",   muldiv_start,   v.mdStart, cyc);
      check("table hilo_busy",      hilo_busy,      v.busy,    cyc);
    end
    if (!rstN) begin
      resetUpTo      = cyc;
      exAt[cyc + 1]  = '0;
      expA[cyc + 1]  = 2'd0;
      expB[cyc + 1]  = 2'd0;
      lastMd         = -1000;
      synced         = 1;
    end else begin
      exAt[cyc + 1] = bubble ? inst_t'(0) : in;
      expA[cyc + 1] = bubble ? 2'd0 : fwdModel(in.usesRs, in.rs, cyc);
      expB[cyc + 1] = bubble ? 2'd0 : fwdModel(in.usesRt, in.rt, cyc);
      if (!bubble && in.muldiv) lastMd = cyc + 1;
    end
    stalled = stall;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  vec_t  vecs[$];
  inst_t cur;
  bit    st, fl, rn;

  initial begin
    // Columns: instruction, flush, reset_n | fwd_a, fwd_b, pc_we, bubble, md_start, busy
    // add r3,r1,r2 ; add r4,r3,r5 : consumer EX gets a=10, b=00
    vecs.push_back(mk(alu(3, 1, 2),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(alu(4, 3, 5),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 2, 0, 1, 1, 0, 0));
    // add r3 ; nop ; sub r6,r7,r3 : b=01
    vecs.push_back(mk(alu(3, 1, 2),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(alu(6, 7, 3),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 0, 1, 1, 1, 0, 0));
    // same with r0 as the producer destination: never forwarded
    vecs.push_back(mk(alu(0, 1, 2),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(alu(6, 7, 0),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 0, 0, 1, 1, 0, 0));
    // lw r5,0(r1) ; add r6,r5,r5 : one stall, then a=b=01
    vecs.push_back(mk(lw(5, 1),      0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(alu(6, 5, 5),  0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(alu(6, 5, 5),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 1, 1, 1, 1, 0, 0));
    // add r2 ; add r2 ; or r8,r2,r0 : newest wins, a=10
    vecs.push_back(mk(alu(2, 1, 1),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(alu(2, 3, 3),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(alu(8, 2, 0),  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 2, 0, 1, 1, 0, 0));
    // mult r1,r2 ; mflo r3 : counter reads 4,3,2,1 over the mflo's first ID
    // cycles, so the adjacent mflo is held for those four cycles
    vecs.push_back(mk(mult(1, 2),    0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(mflo(3),       0, 1, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(mflo(3),       0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(mflo(3),       0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(mflo(3),       0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(mflo(3),       0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 0, 0, 1, 1, 0, 0));
    // load-use squashed by flush_id: no stall, bubble
    vecs.push_back(mk(lw(5, 1),      0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(alu(6, 5, 5),  1, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 0, 0, 1, 1, 0, 0));
    // reset while HI/LO busy and a forward is pending: everything clears
    vecs.push_back(mk(mult(1, 2),    0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(alu(9, 1, 1),  0, 1, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(alu(10, 9, 9), 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(mflo(3),       0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(nop(),         0, 1, 0, 0, 1, 1, 0, 0));

    reset = 1'b0;
    @(posedge clk);
    #1;
    runCycle(nop(), 0, 0, 0, '0, st);
    runCycle(nop(), 0, 0, 0, '0, st);

    for (int k = 0; k < vecs.size(); k++) begin
      runCycle(vecs[k].inst, vecs[k].flush, vecs[k].rstN, 1, vecs[k], st);
    end

    cur = randInst();
    for (int i = 0; i < N_RAND; i++) begin
      fl = ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 199) != 0);
      runCycle(cur, fl, rn, 0, '0, st);
      // a stalled instruction stays in ID; anything else is replaced
      if (!st || !rn) cur = randInst();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
